// File: rtl/prog_counter_pkg.sv
// prog_counter_pkg
// Shared types and arithmetic for the programmable up/down counter.
//   mode_e      : wrap-around or saturating behaviour at the range ends
//   event_e     : boundary event produced by one counting step
//   next_t      : next count plus the event it produced
//   calc_eff_step() : step clamped to the size of the count range
//   calc_next()     : next count and event for one tick
// The arithmetic works at a fixed maximum width (CNT_MAX_W). Any counter up to
// that width zero-extends its operands into these functions and truncates the
// result back.
package prog_counter_pkg;

    localparam int CNT_MAX_W = 32;
    // Two guard bits: count + (limit + 1) can reach almost 2^(CNT_MAX_W+1).
    localparam int EXT_W     = CNT_MAX_W + 2;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } mode_e;

    typedef enum logic [1:0] {
        EV_NONE = 2'd0,
        EV_OVF  = 2'd1,
        EV_UNF  = 2'd2
    } event_e;

    typedef struct packed {
        logic [CNT_MAX_W-1:0] count;
        event_e               ev;
    } next_t;

    // min(step, limit + 1). Computed one bit wider than the operands, so a
    // limit of all-ones gives a full-range step instead of wrapping to 0.
    function automatic logic [CNT_MAX_W:0] calc_eff_step(
        input logic [CNT_MAX_W-1:0] step,
        input logic [CNT_MAX_W-1:0] limit
    );
        logic [CNT_MAX_W:0] range;
        range = {1'b0, limit} + 1'b1;
        return ({1'b0, step} < range) ? {1'b0, step} : range;
    endfunction

    function automatic next_t calc_next(
        input logic [CNT_MAX_W-1:0] count,
        input logic [CNT_MAX_W:0]   eff_step,
        input logic [CNT_MAX_W-1:0] limit,
        input logic                 dir_up,
        input mode_e                mode
    );
        next_t            res;
        logic [EXT_W-1:0] c;
        logic [EXT_W-1:0] e;
        logic [EXT_W-1:0] l;
        logic [EXT_W-1:0] range;
        logic [EXT_W-1:0] val;

        c     = EXT_W'(count);
        e     = EXT_W'(eff_step);
        l     = EXT_W'(limit);
        range = l + 1'b1;
        val   = c;
        res.ev = EV_NONE;

        if (e == '0) begin
            // A zero step is a no-op, even at the range ends.
            val = c;
        end else if (dir_up) begin
            if (c > l) begin
                // The limit was lowered under the count: treat it as having
                // already run off the top.
                res.ev = EV_OVF;
                val    = (mode == MODE_SAT) ? l : '0;
            end else if ((c + e) <= l) begin
                val = c + e;
            end else begin
                res.ev = EV_OVF;
                val    = (mode == MODE_SAT) ? l : (c + e - range);
            end
        end else begin
            if (c >= e) begin
                val = c - e;
            end else begin
                res.ev = EV_UNF;
                val    = (mode == MODE_SAT) ? '0 : (c + range - e);
            end
            // Only reachable when the count started above a lowered limit.
            if (val > l) begin
                val = l;
            end
        end

        res.count = CNT_MAX_W'(val);
        return res;
    endfunction

endpackage

// File: rtl/prog_counter_if.sv
// prog_counter_if
// Bundles the programmable counter's pins for the DUT, a stimulus driver and a
// passive monitor.
//   clk        : shared clock (interface port)
//   rst .. clr_flags      : controls, driven by TEST
//   count_out .. unf_sticky : status, driven by DUT
interface prog_counter_if #(
    parameter int WIDTH   = 8,
    parameter int STEP_W  = 4,
    parameter int PRESC_W = 4
) (
    input logic clk
);

    logic               rst;
    logic               load_n;
    logic               ce;
    logic               up_down;
    logic [WIDTH-1:0]   data_load;
    logic [WIDTH-1:0]   limit;
    logic [STEP_W-1:0]  step;
    logic               sat_mode;
    logic [PRESC_W-1:0] prescale;
    logic               clr_flags;
    logic [WIDTH-1:0]   count_out;
    logic               max_count;
    logic               zero;
    logic               tc_pulse;
    logic               ovf_sticky;
    logic               unf_sticky;

    modport DUT (
        input  clk, rst, load_n, ce, up_down, data_load, limit, step,
               sat_mode, prescale, clr_flags,
        output count_out, max_count, zero, tc_pulse, ovf_sticky, unf_sticky
    );

    modport TEST (
        input  clk, count_out, max_count, zero, tc_pulse, ovf_sticky, unf_sticky,
        output rst, load_n, ce, up_down, data_load, limit, step,
               sat_mode, prescale, clr_flags
    );

    modport MONITOR (
        input clk, rst, load_n, ce, up_down, data_load, limit, step,
              sat_mode, prescale, clr_flags,
              count_out, max_count, zero, tc_pulse, ovf_sticky, unf_sticky
    );

endinterface

// File: rtl/counter_prescaler.sv
// counter_prescaler
// Divides the count enable: tick fires on one of every prescale+1 cycles that
// have ce high. Cycles with ce low freeze the phase.
//   clk, rst  : clock and synchronous active-high reset
//   ce        : enable; only enabled cycles advance the phase
//   prescale  : divide ratio minus one
//   clear     : restart the phase at 0 (used on load)
//   tick      : combinational; high on the enabled cycle that completes a period
module counter_prescaler #(
    parameter int PRESC_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ce,
    input  logic [PRESC_W-1:0] prescale,
    input  logic               clear,
    output logic               tick
);

    logic [PRESC_W-1:0] presc_cnt_q;
    logic [PRESC_W-1:0] presc_cnt_d;

    assign tick = ce && (presc_cnt_q == prescale);

    always_comb begin
        presc_cnt_d = presc_cnt_q;
        if (clear) begin
            presc_cnt_d = '0;
        end else if (tick) begin
            presc_cnt_d = '0;
        end else if (ce) begin
            presc_cnt_d = presc_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_cnt_q <= '0;
        end else begin
            presc_cnt_q <= presc_cnt_d;
        end
    end

endmodule

// File: rtl/prog_updown_counter.sv
// prog_updown_counter
// Up/down counter over the range 0..limit with a programmable step, wrap or
// saturate behaviour at the ends, a prescaled count enable, a one-cycle
// terminal-count pulse and sticky overflow/underflow flags.
//   clk, rst    : clock and synchronous active-high reset
//   load_n      : active-low load of min(data_load, limit); wins over counting
//   ce          : count enable into the prescaler
//   up_down     : 1 counts up, 0 counts down
//   data_load   : load value
//   limit       : top of the count range
//   step        : amount per tick (clamped to limit+1)
//   sat_mode    : 1 saturates at the ends, 0 wraps modulo limit+1
//   prescale    : counting advances once per prescale+1 enabled cycles
//   clr_flags   : clears the sticky flags (a same-cycle event wins)
//   count_out   : registered count
//   max_count   : count_out == limit
//   zero        : count_out == 0
//   tc_pulse    : registered; a boundary event happened on the last update
//   ovf_sticky  : an up-direction boundary event has happened
//   unf_sticky  : a down-direction boundary event has happened
module prog_updown_counter
    import prog_counter_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int STEP_W  = 4,
    parameter int PRESC_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_n,
    input  logic               ce,
    input  logic               up_down,
    input  logic [WIDTH-1:0]   data_load,
    input  logic [WIDTH-1:0]   limit,
    input  logic [STEP_W-1:0]  step,
    input  logic               sat_mode,
    input  logic [PRESC_W-1:0] prescale,
    input  logic               clr_flags,
    output logic [WIDTH-1:0]   count_out,
    output logic               max_count,
    output logic               zero,
    output logic               tc_pulse,
    output logic               ovf_sticky,
    output logic               unf_sticky
);

    logic [WIDTH-1:0]   count_q;
    logic [WIDTH-1:0]   count_d;
    logic               tc_q;
    logic               tc_d;
    logic               ovf_q;
    logic               ovf_d;
    logic               unf_q;
    logic               unf_d;

    logic               load;
    logic               tick;
    logic [CNT_MAX_W:0] eff_step;
    next_t              nxt;

    assign load = ~load_n;

    // A load restarts the prescaler so the first tick after it is a full
    // period away.
    counter_prescaler #(
        .PRESC_W (PRESC_W)
    ) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .ce       (ce),
        .prescale (prescale),
        .clear    (load),
        .tick     (tick)
    );

    always_comb begin
        eff_step = calc_eff_step(CNT_MAX_W'(step), CNT_MAX_W'(limit));
        nxt      = calc_next(CNT_MAX_W'(count_q), eff_step, CNT_MAX_W'(limit),
                             up_down, mode_e'(sat_mode));
    end

    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        ovf_d   = ovf_q & ~clr_flags;
        unf_d   = unf_q & ~clr_flags;

        if (load) begin
            count_d = (data_load > limit) ? limit : data_load;
        end else if (tick) begin
            count_d = WIDTH'(nxt.count);
            tc_d    = (nxt.ev != EV_NONE);
            // Setting after the clear term lets a same-cycle event win.
            if (nxt.ev == EV_OVF) begin
                ovf_d = 1'b1;
            end
            if (nxt.ev == EV_UNF) begin
                unf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign count_out  = count_q;
    assign max_count  = (count_q == limit);
    assign zero       = (count_q == '0);
    assign tc_pulse   = tc_q;
    assign ovf_sticky = ovf_q;
    assign unf_sticky = unf_q;

endmodule

// File: tb/tb_prog_updown_counter.sv
// tb_prog_updown_counter
// Directed bench for prog_updown_counter at WIDTH=4. Each check compares a
// status word {count_out, max_count, zero, tc_pulse, ovf_sticky, unf_sticky}
// sampled 1 time unit after the rising edge against a hand-computed value.
module tb_prog_updown_counter;

    localparam int WIDTH   = 4;
    localparam int STEP_W  = 4;
    localparam int PRESC_W = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    prog_counter_if #(
        .WIDTH   (WIDTH),
        .STEP_W  (STEP_W),
        .PRESC_W (PRESC_W)
    ) cif (
        .clk (clk)
    );

    prog_updown_counter #(
        .WIDTH   (WIDTH),
        .STEP_W  (STEP_W),
        .PRESC_W (PRESC_W)
    ) dut (
        .clk        (clk),
        .rst        (cif.rst),
        .load_n     (cif.load_n),
        .ce         (cif.ce),
        .up_down    (cif.up_down),
        .data_load  (cif.data_load),
        .limit      (cif.limit),
        .step       (cif.step),
        .sat_mode   (cif.sat_mode),
        .prescale   (cif.prescale),
        .clr_flags  (cif.clr_flags),
        .count_out  (cif.count_out),
        .max_count  (cif.max_count),
        .zero       (cif.zero),
        .tc_pulse   (cif.tc_pulse),
        .ovf_sticky (cif.ovf_sticky),
        .unf_sticky (cif.unf_sticky)
    );

    int         checks = 0;
    int         errors = 0;
    logic [8:0] exp_st;
    logic [8:0] wrap_exp [4];
    logic [3:0] presc_exp [13];

    function automatic logic [8:0] status();
        return {cif.count_out, cif.max_count, cif.zero, cif.tc_pulse,
                cif.ovf_sticky, cif.unf_sticky};
    endfunction

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [3:0] value);
        cif.load_n    = 1'b0;
        cif.data_load = value;
        step_clk();
        cif.load_n    = 1'b1;
    endtask

    task automatic test_reset();
        cif.rst = 1'b1;
        step_clk();
        cif.rst = 1'b0;
        exp_st = {4'd0, 5'b01000};
        checks++;
        if (status() !== exp_st) begin
            errors++;
            $display("FAIL reset_first_edge: got %b expected %b", status(), exp_st);
        end

        do_load(4'd7);
        exp_st = {4'd7, 5'b00000};
        checks++;
        if (status() !== exp_st) begin
            errors++;
            $display("FAIL reset_preload: got %b expected %b", status(), exp_st);
        end

        // Reset together with a load and an enable: reset wins.
        cif.rst       = 1'b1;
        cif.load_n    = 1'b0;
        cif.data_load = 4'd3;
        cif.ce        = 1'b1;
        step_clk();
        cif.rst    = 1'b0;
        cif.load_n = 1'b1;
        cif.ce     = 1'b0;
        exp_st = {4'd0, 5'b01000};
        checks++;
        if (status() !== exp_st) begin
            errors++;
            $display("FAIL reset_from_7: got %b expected %b", status(), exp_st);
        end
    endtask

    task automatic test_wrap_up();
        cif.limit    = 4'd9;
        cif.step     = 4'd3;
        cif.sat_mode = 1'b0;
        cif.prescale = 4'd0;
        cif.up_down  = 1'b1;
        do_load(4'd8);
        exp_st = {4'd8, 5'b00000};
        checks++;
        if (status() !== exp_st) begin
            errors++;
            $display("FAIL wrap_load8: got %b expected %b", status(), exp_st);
        end

        wrap_exp[0] = {4'd1, 5'b00110};
        wrap_exp[1] = {4'd4, 5'b00010};
        wrap_exp[2] = {4'd7, 5'b00010};
        wrap_exp[3] = {4'd0, 5'b01110};
        cif.ce = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step_clk();
            checks++;
            if (status() !== wrap_exp[i]) begin
                errors++;
                $display("FAIL wrap_up_tick%0d: got %b expected %b", i, status(), wrap_exp[i]);
            end
        end
        cif.ce = 1'b0;
        step_clk();
        exp_st = {4'd0, 5'b01010};
        checks++;
        if (status() !== exp_st) begin
            errors++;
            $display("FAIL wrap_tc_drop: got %b expected %b", status(), exp_st);
        end
    endtask

    task automatic test_sat_down();
        cif.clr_flags = 1'b1;
        step_clk();
        cif.clr_flags = 1'b0;
        exp_st = {4'd0, 5'b01000};
        checks++;
        if (status() !== exp_st) begin
            errors++;
            $display("FAIL sat_clr_flags: got %b expected %b", status(), exp_st);
        end

        cif.sat_mode = 1'b1;
        cif.up_down  = 1'b0;
        do_load(4'd2);
        exp_st = {4'd2, 5'b00000};
        checks++;
        if (status() !== exp_st) begin
            errors++;
            $display("FAIL sat_load2: got %b expected %b", status(), exp_st);
        end

        cif.ce = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step_clk();
            exp_st = {4'd0, 5'b01101};
            checks++;
            if (status() !== exp_st) begin
                errors++;
                $display("FAIL sat_down_tick%0d: got %b expected %b", i, status(), exp_st);
            end
        end
        cif.ce = 1'b0;
        step_clk();
        exp_st = {4'd0, 5'b01001};
        checks++;
        if (status() !== exp_st) begin
            errors++;
            $display("FAIL sat_tc_drop: got %b expected %b", status(), exp_st);
        end
    endtask

    task automatic test_prescaler();
        cif.sat_mode = 1'b0;
        cif.up_down  = 1'b1;
        cif.step     = 4'd1;
        cif.prescale = 4'd2;
        do_load(4'd0);
        presc_exp = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd2, 4'd2,
                      4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd3};
        // ce low on edges 8..11 stalls the prescaler for four cycles.
        for (int e = 1; e <= 13; e++) begin
            cif.ce = (e >= 8 && e <= 11) ? 1'b0 : 1'b1;
            step_clk();
            exp_st = {presc_exp[e-1], 1'b0, (presc_exp[e-1] == 4'd0), 3'b001};
            checks++;
            if (status() !== exp_st) begin
                errors++;
                $display("FAIL presc_edge%0d: got %b expected %b", e, status(), exp_st);
            end
        end
    endtask

    task automatic test_load_priority();
        cif.ce = 1'b1;
        step_clk();
        step_clk();
        exp_st = {4'd3, 5'b00001};
        checks++;
        if (status() !== exp_st) begin
            errors++;
            $display("FAIL ldpri_before: got %b expected %b", status(), exp_st);
        end

        // The prescaler is at its terminal phase, so this edge also ticks.
        do_load(4'd12);
        exp_st = {4'd9, 5'b10001};
        checks++;
        if (status() !== exp_st) begin
            errors++;
            $display("FAIL ldpri_clamp: got %b expected %b", status(), exp_st);
        end

        for (int i = 0; i < 2; i++) begin
            step_clk();
            exp_st = {4'd9, 5'b10001};
            checks++;
            if (status() !== exp_st) begin
                errors++;
                $display("FAIL ldpri_hold%0d: got %b expected %b", i, status(), exp_st);
            end
        end
        step_clk();
        exp_st = {4'd0, 5'b01111};
        checks++;
        if (status() !== exp_st) begin
            errors++;
            $display("FAIL ldpri_first_tick: got %b expected %b", status(), exp_st);
        end
        cif.ce = 1'b0;
    endtask

    task automatic test_flags();
        cif.prescale  = 4'd0;
        cif.step      = 4'd3;
        cif.clr_flags = 1'b1;
        step_clk();
        cif.clr_flags = 1'b0;
        exp_st = {4'd0, 5'b01000};
        checks++;
        if (status() !== exp_st) begin
            errors++;
            $display("FAIL flags_clear_both: got %b expected %b", status(), exp_st);
        end

        do_load(4'd8);
        cif.ce        = 1'b1;
        cif.clr_flags = 1'b1;
        step_clk();
        exp_st = {4'd1, 5'b00110};
        checks++;
        if (status() !== exp_st) begin
            errors++;
            $display("FAIL flags_set_wins: got %b expected %b", status(), exp_st);
        end

        cif.ce = 1'b0;
        step_clk();
        cif.clr_flags = 1'b0;
        exp_st = {4'd1, 5'b00000};
        checks++;
        if (status() !== exp_st) begin
            errors++;
            $display("FAIL flags_clear_alone: got %b expected %b", status(), exp_st);
        end

        do_load(4'd7);
        cif.limit = 4'd3;
        cif.ce    = 1'b1;
        step_clk();
        cif.ce = 1'b0;
        exp_st = {4'd0, 5'b01110};
        checks++;
        if (status() !== exp_st) begin
            errors++;
            $display("FAIL flags_above_limit_up: got %b expected %b", status(), exp_st);
        end

        cif.limit = 4'd9;
        do_load(4'd7);
        cif.limit   = 4'd3;
        cif.up_down = 1'b0;
        cif.step    = 4'd1;
        cif.ce      = 1'b1;
        step_clk();
        cif.ce = 1'b0;
        exp_st = {4'd3, 5'b10010};
        checks++;
        if (status() !== exp_st) begin
            errors++;
            $display("FAIL above_limit_down_clamp: got %b expected %b", status(), exp_st);
        end
    endtask

    task automatic test_step_edges();
        cif.limit   = 4'd3;
        cif.up_down = 1'b1;
        cif.step    = 4'd0;
        do_load(4'd2);
        cif.ce = 1'b1;
        step_clk();
        exp_st = {4'd2, 5'b00010};
        checks++;
        if (status() !== exp_st) begin
            errors++;
            $display("FAIL step_zero: got %b expected %b", status(), exp_st);
        end

        // step 9 exceeds limit+1 = 4, so it counts as a full-range step.
        cif.step = 4'd9;
        step_clk();
        exp_st = {4'd2, 5'b00110};
        checks++;
        if (status() !== exp_st) begin
            errors++;
            $display("FAIL step_big_up: got %b expected %b", status(), exp_st);
        end

        cif.up_down = 1'b0;
        step_clk();
        exp_st = {4'd2, 5'b00111};
        checks++;
        if (status() !== exp_st) begin
            errors++;
            $display("FAIL step_big_down: got %b expected %b", status(), exp_st);
        end
    endtask

    task automatic test_mid_reset();
        cif.rst = 1'b1;
        step_clk();
        cif.rst = 1'b0;
        cif.ce  = 1'b0;
        exp_st = {4'd0, 5'b01000};
        checks++;
        if (status() !== exp_st) begin
            errors++;
            $display("FAIL mid_reset: got %b expected %b", status(), exp_st);
        end
    endtask

    initial begin
        cif.rst       = 1'b1;
        cif.load_n    = 1'b1;
        cif.ce        = 1'b0;
        cif.up_down   = 1'b1;
        cif.data_load = 4'd0;
        cif.limit     = 4'd9;
        cif.step      = 4'd3;
        cif.sat_mode  = 1'b0;
        cif.prescale  = 4'd0;
        cif.clr_flags = 1'b0;

        test_reset();
        test_wrap_up();
        test_sat_down();
        test_prescaler();
        test_load_priority();
        test_flags();
        test_step_edges();
        test_mid_reset();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/prog_updown_counter.md
Name: prog_updown_counter

Overview:
Second-generation up/down counter. It extends the basic load/enable/direction counter with a programmable upper limit, a programmable step size, wrap or saturate modes, a clock-enable prescaler, a terminal-count pulse and sticky overflow/underflow flags. It sits in the same verification environment as the existing counter and keeps the signal names clk, load_n, up_down, ce, data_load, count_out, max_count and zero.

Parameters:
WIDTH, 8, bit width of count_out, data_load and limit
STEP_W, 4, bit width of step
PRESC_W, 4, bit width of prescale

Ports:
clk  input  1  single clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
load_n  input  1  active-low synchronous load
ce  input  1  count enable; feeds the prescaler
up_down  input  1  1 = count up, 0 = count down
data_load  input  WIDTH  value to load
limit  input  WIDTH  count range is 0..limit
step  input  STEP_W  increment/decrement amount per tick
sat_mode  input  1  1 = saturate, 0 = wrap modulo (limit+1)
prescale  input  PRESC_W  count advances once every prescale+1 enabled cycles
clr_flags  input  1  clears the sticky flags
count_out  output  WIDTH  registered count
max_count  output  1  combinational: count_out == limit
zero  output  1  combinational: count_out == 0
tc_pulse  output  1  registered, one cycle; a boundary event occurred on this update
ovf_sticky  output  1  registered; an up-direction boundary event has occurred
unf_sticky  output  1  registered; a down-direction boundary event has occurred

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: count_out=0, prescaler=0, tc_pulse=0, ovf_sticky=0, unf_sticky=0. Outputs reflect these after the first edge with rst=1. Reset takes effect mid-operation on the same edge, regardless of other inputs.
- Priority per edge: rst > load (load_n=0) > tick.
- Load: count_out <= min(data_load, limit). Prescaler is cleared. tc_pulse=0. Flags are unchanged.
- Prescaler: presc_cnt advances only while ce=1. A tick occurs when ce=1 and presc_cnt==prescale; presc_cnt then returns to 0. ce=0 holds presc_cnt. With prescale=0, every ce cycle is a tick.
- eff_step = min(step, limit+1), computed in WIDTH+1 bits so limit=all-ones does not overflow. eff_step=0 leaves the count unchanged and is not a boundary event.
- Up tick: sum = count+eff_step, in WIDTH+1 bits.
  - sum <= limit: count <= sum.
  - Otherwise this is an overflow event. Wrap mode: count <= sum-(limit+1). Saturate mode: count <= limit.
- Down tick:
  - count >= eff_step: count <= count-eff_step.
  - Otherwise this is an underflow event. Wrap mode: count <= count+(limit+1)-eff_step. Saturate mode: count <= 0.
- Saturate repeats: in saturate mode, an up tick at limit (or a down tick at 0) with eff_step>0 is again a boundary event. The count holds and tc_pulse re-asserts.
- Count above limit: if count > limit because limit was lowered at runtime, an up tick is an overflow (result 0 in wrap, limit in saturate). A down tick result is clamped to limit.
- tc_pulse is 1 on the edge following the update where a boundary event occurred, aligned with the new count_out. Otherwise it is 0.
- ovf_sticky/unf_sticky set on their events and clear on clr_flags=1. A same-cycle set wins over clear.
- max_count and zero are derived from the count register only; no extra latency.

Decomposition:
- Package prog_counter_pkg holds:
  - typedef enum {MODE_WRAP, MODE_SAT}
  - typedef enum {EV_NONE, EV_OVF, EV_UNF}
  - a function computing the next count and event from (count, eff_step, limit, dir, mode), shared by RTL and the scoreboard model.
- One sub-module, counter_prescaler: inputs clk, rst, ce, prescale, clear; output tick.
- Companion interface prog_counter_if with DUT, TEST and MONITOR modports.

Test Plan:
1. Reset: count_out=7, rst=1 for one edge -> count_out=0, zero=1, tc_pulse=0, both flags 0.
2. Wrap up (WIDTH=4, limit=9, step=3, sat_mode=0, prescale=0): load 8, ce=1, up -> counts 1, 4, 7, 0. tc_pulse=1 with the 1 and with the 0. ovf_sticky=1.
3. Saturate down (limit=9, step=3, sat_mode=1): load 2, ce=1, down -> 0 (tc_pulse=1, unf_sticky=1), then 0 again with tc_pulse=1 each tick.
4. Prescaler (prescale=2, step=1, up): from 0 with ce=1 -> count 1 at edge 3, 2 at edge 6. Drop ce for 4 cycles at edge 7 -> next increment is delayed exactly 4 cycles.
5. Load priority: load_n=0, data_load=12, limit=9, same cycle as a tick -> count_out=9, max_count=1, tc_pulse=0, next tick waits a full prescale period.
6. Flags: clr_flags=1 on the same edge as an overflow -> ovf_sticky stays 1. clr_flags=1 alone -> 0. Then lower limit to 3 with count 7, up tick, wrap mode -> count 0, ovf_sticky=1.
